mewb_mem_stage: RTL

Memory-stage controller that consumes the EX/ME pipeline register outputs and drives the ME/WB boundary of the 16-bit pipelined CPU. It issues loads and stores to data memory over a valid/ready request port, waits for read responses, and stalls the upstream pipeline until the access resolves. It then registers the result, the control signals and the N/V/Z flags into the writeback stage. Instructions that do not access memory pass through with one-cycle latency.

---
 rtl/mewb_mem_stage_if.sv | 22 ++
 rtl/mewb_mem_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mewb_mem_stage_if.sv
// rtl/mewb_mem_stage_if.sv - data-memory request/response port between the ME stage and memory
interface mewb_mem_stage_if #(
  parameter int DATA_W = 16
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_wdata, mem_we,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr, mem_wdata, mem_we,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/mewb_mem_stage.sv
// rtl/mewb_mem_stage.sv - ME stage controller: issues loads/stores, stalls upstream, registers ME/WB
module mewb_mem_stage #(
  parameter int DATA_W  = 16,
  parameter int RA_W    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic [RA_W-1:0]   WA3M,
  input  logic              NM,
  input  logic              VM,
  input  logic              ZM,
  output logic              StallM,
  mewb_mem_stage_if.master  mem,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic              RegWriteW,
  output logic              MemToRegW,
  output logic              MemErrW,
  output logic [RA_W-1:0]   WA3W,
  output logic              NW,
  output logic              VW,
  output logic              ZW
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [7:0] TMO    = 8'(TIMEOUT);

  logic [1:0]        state;
  logic [DATA_W-1:0] req_addr, req_wdata, rd_data;
  logic              req_we, req_load, req_rw, req_err;
  logic              req_n, req_v, req_z;
  logic [RA_W-1:0]   req_wa;
  logic [7:0]        wait_cnt;
  logic              acc;

  assign acc    = MemReadM | MemWriteM;
  assign StallM = !reset && ((state == S_IDLE && acc) || state == S_REQ || state == S_WAIT);

  assign mem.mem_req_valid = (state == S_REQ);
  assign mem.mem_addr      = req_addr;
  assign mem.mem_wdata     = req_wdata;
  assign mem.mem_we        = req_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
      req_load  <= 1'b0;
      req_rw    <= 1'b0;
      req_err   <= 1'b0;
      req_n     <= 1'b0;
      req_v     <= 1'b0;
      req_z     <= 1'b0;
      req_wa    <= '0;
      rd_data   <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (acc) begin
            // A store wins over a simultaneous read request.
            req_addr  <= ALUResultM;
            req_wdata <= WriteDataM;
            req_we    <= MemWriteM;
            req_load  <= MemReadM & ~MemWriteM;
            req_rw    <= RegWriteM;
            req_wa    <= WA3M;
            req_n     <= NM;
            req_v     <= VM;
            req_z     <= ZM;
            req_err   <= 1'b0;
            rd_data   <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem.mem_req_ready) begin
            wait_cnt <= '0;
            state    <= req_we ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_rsp_valid) begin
            rd_data <= mem.mem_rdata;
            state   <= S_DONE;
          end else if (wait_cnt == TMO) begin
            rd_data <= '0;
            req_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ME/WB register: pass-through in IDLE without access, captured op in DONE, bubble otherwise.
  always_ff @(posedge clk) begin
    if (reset || (state == S_IDLE && acc) || state == S_REQ || state == S_WAIT) begin
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RegWriteW  <= 1'b0;
      MemToRegW  <= 1'b0;
      MemErrW    <= 1'b0;
      WA3W       <= '0;
      NW         <= 1'b0;
      VW         <= 1'b0;
      ZW         <= 1'b0;
    end else if (state == S_DONE) begin
      ALUResultW <= req_addr;
      ReadDataW  <= rd_data;
      RegWriteW  <= req_rw & ~req_err;
      MemToRegW  <= req_load;
      MemErrW    <= req_err;
      WA3W       <= req_wa;
      NW         <= req_n;
      VW         <= req_v;
      ZW         <= req_z;
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= '0;
      RegWriteW  <= RegWriteM;
      MemToRegW  <= 1'b0;
      MemErrW    <= 1'b0;
      WA3W       <= WA3M;
      NW         <= NM;
      VW         <= VM;
      ZW         <= ZM;
    end
  end
endmodule
